pwm_channel_driver: RTL and testbench
=====================================

// Module: pwm_channel_driver
// PURPOSE
//  Generalised per-colour-component LED driver for the cube panels: N-channel PWM comparator bank,
//  host-writable brightness register and an internal frame sequencer. The sequencer serialises
//  either PWM state or brightness into an external constant-current driver chain via sdo/sclk/latch.
//  One instance sits per colour component, beneath the panel controller, which issues start pulses.
// PARAMETERS
//  CHANNELS     16  LEDs driven per instance; also the shift-frame length in bits
//  PWM_BITS     8   width of each component value and of pwm_time
//  BRIGHT_BITS  8   width of brightness register; must be <= CHANNELS (elaboration $error otherwise)
// PORTS
//  clk               in   1                    system clock; all logic on rising edge
//  reset_n           in   1                    asynchronous, active-low reset
//  pwm_time          in   PWM_BITS             free-running PWM timebase from panel controller
//  component_values  in   CHANNELS*PWM_BITS    channel i occupies bits [PWM_BITS*i +: PWM_BITS]
//  brightness_in     in   BRIGHT_BITS          new brightness value
//  brightness_we     in   1                    write strobe for brightness_in
//  start             in   1                    one-cycle request to send a frame
//  frame_sel         in   1                    sampled with start: 0 = PWM data frame, 1 = brightness frame
//  busy              out  1                    high from cycle after accepted start until done
//  done              out  1                    one-cycle pulse: frame complete
//  sdo               out  1                    serial data to driver chain, MSB (channel CHANNELS-1) first
//  sclk              out  1                    shift clock to driver chain
//  latch             out  1                    one-cycle latch strobe after last bit
// BEHAVIOUR
//  Reset: busy=0, done=0, sdo=0, sclk=0, latch=0, FSM=IDLE, brightness reg = all ones, shift reg = 0.
//  Reset is asserted asynchronously mid-frame: all outputs return to reset values immediately; no partial latch occurs.
//  Comparator: pwm_bit[i] = (pwm_time < value[i]), unsigned. value=0 gives always off; value=2^PWM_BITS-1 gives off only at max time.
//  Brightness register: written on any clk with brightness_we=1, including while busy.
//   A write takes effect at the next LOAD only; an in-flight frame is unaffected.
//  FSM states: IDLE -> LOAD -> SHIFT -> LATCH -> DONE -> IDLE.
//   IDLE:  start=1 accepted and frame_sel captured; next state LOAD. start outside IDLE is ignored (no queueing).
//   LOAD:  1 cycle; busy=1. Shift reg <= pwm_bit vector if frame_sel=0.
//          If frame_sel=1, shift reg <= zero-extended {0.., brightness}. pwm_time is sampled only in this cycle.
//   SHIFT: 2 cycles per bit, CHANNELS bits; bit counter runs 0..CHANNELS-1.
//          phase0: sdo <= sr[MSB], sclk=0. phase1: sclk=1, sdo held; sr shifts left at end of phase1.
//          After the last bit's phase1, next state LATCH; sdo returns to 0.
//   LATCH: 1 cycle latch=1, sclk=0.
//   DONE:  1 cycle done=1, busy=0; next state IDLE. A start in this cycle is ignored.
//  Latency (start sampled at cycle 0): LOAD c1, first sclk high c3, latch c(2+2*CHANNELS), done c(3+2*CHANNELS).
//   CHANNELS=16 gives latch at c34 and done at c35. Minimum start-to-start spacing is 4+2*CHANNELS.
//  Outputs sdo/sclk/latch/busy/done are all registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  PWM_TEST_PANEL_REMAP_EN defined:
//   adds input port test_panel_select (1 bit, after frame_sel).
//   When test_panel_select=1 at LOAD of a data frame, the pwm_bit vector is bit-reversed before loading
//   (channel 0 shifts first), matching test-panel wiring. Brightness frames are never remapped.
//  PWM_TEST_PANEL_REMAP_EN undefined: port absent; channel CHANNELS-1 always shifts first.
// TESTING
//  1 Reset: hold reset_n=0 5 cycles -> busy/done/sdo/sclk/latch=0. Brightness frame -> 16 bits 0x00FF.
//  2 Data frame, CHANNELS=16: value[i]=16*i, pwm_time=0x50 -> bits 15..6 =1, 5..0 =0.
//    Serial stream 0xFFC0; latch at c34, done at c35.
//  3 Boundary: value=0x00 and 0xFF with pwm_time=0xFF -> both bits 0; with pwm_time=0x00 -> 0 and 1.
//  4 brightness_we=1, data 0x3C, mid brightness frame -> current frame still shifts 0x00FF;
//    next brightness frame shifts 0x003C.
//  5 start pulses at c5 and in DONE cycle -> ignored (single frame). Reset at c10 mid-shift -> outputs 0 at once, no latch.
//  6 Macro on: test_panel_select=1 with stimulus of test 2 -> stream 0x03FF. Brightness frame stays 0x00FF.

Source files
------------

// File: rtl/pwm_channel_driver.sv
// Per-colour PWM comparator bank with a frame sequencer that serialises PWM bits or brightness to an LED driver chain.
// Optional build macro PWM_TEST_PANEL_REMAP_EN adds test_panel_select for bit-reversed data frames.
module pwm_channel_driver #(
  parameter int CHANNELS    = 16,
  parameter int PWM_BITS    = 8,
  parameter int BRIGHT_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [PWM_BITS-1:0]          pwm_time,
  input  logic [CHANNELS*PWM_BITS-1:0] component_values,
  input  logic [BRIGHT_BITS-1:0]       brightness_in,
  input  logic                         brightness_we,
  input  logic                         start,
  input  logic                         frame_sel,
`ifdef PWM_TEST_PANEL_REMAP_EN
  input  logic                         test_panel_select,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         sdo,
  output logic                         sclk,
  output logic                         latch
);

  localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHANNELS - 1);

  if (BRIGHT_BITS > CHANNELS) begin : g_bright_chk
    $error("BRIGHT_BITS must not exceed CHANNELS");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CHANNELS-1:0]    r_sr;
  logic [CHANNELS-1:0]    w_sr_shl;
  logic [CHANNELS-1:0]    w_pwm_bits;
  logic [CHANNELS-1:0]    w_data_vec;
  logic [CHANNELS-1:0]    w_load_vec;
  logic [BRIGHT_BITS-1:0] r_bright;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_phase;
  logic                   r_frame_sel;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_sdo;
  logic                   r_sclk;
  logic                   r_latch;

  assign busy  = r_busy;
  assign done  = r_done;
  assign sdo   = r_sdo;
  assign sclk  = r_sclk;
  assign latch = r_latch;

  assign w_sr_shl = r_sr << 1;

  // Comparator bank and frame-vector selection; only consumed during LOAD
  always_comb begin
    w_pwm_bits = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_pwm_bits[i] = (pwm_time < component_values[PWM_BITS*i +: PWM_BITS]);
    end
    w_data_vec = w_pwm_bits;
`ifdef PWM_TEST_PANEL_REMAP_EN
    if (test_panel_select) begin
      for (int i = 0; i < CHANNELS; i++) begin
        w_data_vec[i] = w_pwm_bits[CHANNELS-1-i];
      end
    end
`endif
    w_load_vec = '0;
    if (r_frame_sel) begin
      w_load_vec[BRIGHT_BITS-1:0] = r_bright;
    end else begin
      w_load_vec = w_data_vec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_phase && (r_bit_cnt == LAST_BIT)) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift datapath: sdo is set up a full cycle before each sclk rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr        <= '0;
      r_bright    <= '1;
      r_bit_cnt   <= '0;
      r_phase     <= 1'b0;
      r_frame_sel <= 1'b0;
      r_sdo       <= 1'b0;
    end else begin
      if (brightness_we) r_bright <= brightness_in;
      case (r_state)
        S_IDLE: begin
          if (start) r_frame_sel <= frame_sel;
          r_sdo <= 1'b0;
        end
        S_LOAD: begin
          r_sr      <= w_load_vec;
          r_sdo     <= w_load_vec[CHANNELS-1];
          r_phase   <= 1'b0;
          r_bit_cnt <= '0;
        end
        S_SHIFT: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase   <= 1'b0;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_sr      <= w_sr_shl;
            r_sdo     <= (r_bit_cnt == LAST_BIT) ? 1'b0 : w_sr_shl[CHANNELS-1];
          end
        end
        default: r_sdo <= 1'b0;
      endcase
    end
  end

  // Control outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT) ||
                 (w_state_nxt == S_LATCH);
      r_done  <= (w_state_nxt == S_DONE);
      r_latch <= (w_state_nxt == S_LATCH);
      r_sclk  <= (r_state == S_SHIFT) && !r_phase;
    end
  end

endmodule

// File: tb/tb_pwm_channel_driver.sv
// Directed bench for pwm_channel_driver (CHANNELS=16, PWM_BITS=8, BRIGHT_BITS=8).
// The remap scenario runs only when PWM_TEST_PANEL_REMAP_EN is defined.
module tb_pwm_channel_driver;

  logic         clk;
  logic         reset_n;
  logic [7:0]   pwm_time;
  logic [127:0] component_values;
  logic [7:0]   brightness_in;
  logic         brightness_we;
  logic         start;
  logic         frame_sel;
`ifdef PWM_TEST_PANEL_REMAP_EN
  logic         test_panel_select;
`endif
  logic         busy;
  logic         done;
  logic         sdo;
  logic         sclk;
  logic         latch;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_channel_driver #(.CHANNELS(16), .PWM_BITS(8), .BRIGHT_BITS(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pwm_time         (pwm_time),
    .component_values (component_values),
    .brightness_in    (brightness_in),
    .brightness_we    (brightness_we),
    .start            (start),
    .frame_sel        (frame_sel),
`ifdef PWM_TEST_PANEL_REMAP_EN
    .test_panel_select(test_panel_select),
`endif
    .busy             (busy),
    .done             (done),
    .sdo              (sdo),
    .sclk             (sclk),
    .latch            (latch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) component_values[8*i +: 8] = 8'(16 * i);
  endtask

  // Starts a frame in cycle 0 and observes cycles 1..45; optional brightness write and extra start pulses
  task automatic run_frame(input logic fsel, input int we_c, input logic [7:0] we_d,
                           input int st_a, input int st_b,
                           output logic [15:0] stream, output int lat_c, output int don_c,
                           output int nlat, output logic busy1, output logic busy_after);
    stream = '0; lat_c = -1; don_c = -1; nlat = 0; busy1 = 1'b0; busy_after = 1'b0;
    frame_sel = fsel;
    start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      start = (c == st_a) || (c == st_b);
      brightness_we = (c == we_c);
      brightness_in = we_d;
      if (c == 1) busy1 = busy;
      if (c >= 36 && busy) busy_after = 1'b1;
      if (sclk) stream = {stream[14:0], sdo};
      if (latch) begin nlat++; lat_c = c; end
      if (done && don_c < 0) don_c = c;
    end
    start = 1'b0;
    brightness_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] s; int lc, dc, nl; logic b1, ba;
    reset_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({busy, done, sdo, sclk, latch} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got %b exp 00000", k, {busy, done, sdo, sclk, latch});
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b1, -1, 8'h00, -1, -1, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (s !== 16'h00FF) begin
      n_fail++; $display("FAIL reset_bright_frame got %h exp 00ff", s);
    end
  endtask

  task automatic test_data_frame();
    logic [15:0] s; int lc, dc, nl; logic b1, ba;
    set_ramp();
    pwm_time = 8'h50;
    run_frame(1'b0, -1, 8'h00, -1, -1, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (s !== 16'hFFC0) begin n_fail++; $display("FAIL data_stream got %h exp ffc0", s); end
    n_tests++;
    if (lc !== 34) begin n_fail++; $display("FAIL data_latch_cycle got %0d exp 34", lc); end
    n_tests++;
    if (dc !== 35) begin n_fail++; $display("FAIL data_done_cycle got %0d exp 35", dc); end
    n_tests++;
    if (nl !== 1) begin n_fail++; $display("FAIL data_latch_count got %0d exp 1", nl); end
    n_tests++;
    if (b1 !== 1'b1) begin n_fail++; $display("FAIL data_busy_c1 got %b exp 1", b1); end
  endtask

  task automatic test_boundary();
    logic [15:0] s; int lc, dc, nl; logic b1, ba;
    for (int i = 0; i < 16; i++) component_values[8*i +: 8] = 8'h80;
    component_values[7:0]  = 8'h00;
    component_values[15:8] = 8'hFF;
    pwm_time = 8'hFF;
    run_frame(1'b0, -1, 8'h00, -1, -1, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (s !== 16'h0000) begin n_fail++; $display("FAIL bound_tmax got %h exp 0000", s); end
    pwm_time = 8'h00;
    run_frame(1'b0, -1, 8'h00, -1, -1, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (s !== 16'hFFFE) begin n_fail++; $display("FAIL bound_tmin got %h exp fffe", s); end
  endtask

  task automatic test_bright_write();
    logic [15:0] s; int lc, dc, nl; logic b1, ba;
    run_frame(1'b1, 10, 8'h3C, -1, -1, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (s !== 16'h00FF) begin n_fail++; $display("FAIL bright_inflight got %h exp 00ff", s); end
    run_frame(1'b1, -1, 8'h00, -1, -1, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (s !== 16'h003C) begin n_fail++; $display("FAIL bright_next got %h exp 003c", s); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s; int lc, dc, nl; logic b1, ba;
    set_ramp();
    pwm_time = 8'h50;
    run_frame(1'b0, -1, 8'h00, 5, 35, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (nl !== 1 || lc !== 34) begin
      n_fail++; $display("FAIL ignore_start latches got %0d at c%0d exp 1 at c34", nl, lc);
    end
    n_tests++;
    if (ba !== 1'b0) begin n_fail++; $display("FAIL ignore_start_busy_after got %b exp 0", ba); end
    n_tests++;
    if (s !== 16'hFFC0) begin n_fail++; $display("FAIL ignore_start_stream got %h exp ffc0", s); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] s; int lc, dc, nl; logic b1, ba; logic seen_latch;
    set_ramp();
    pwm_time = 8'h50;
    frame_sel = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_tests++;
    if ({busy, sdo} !== 2'b11) begin
      n_fail++; $display("FAIL midframe_pre busy,sdo got %b exp 11", {busy, sdo});
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, sdo, sclk, latch} !== 5'b0) begin
      n_fail++; $display("FAIL async_reset_outputs got %b exp 00000", {busy, done, sdo, sclk, latch});
    end
    seen_latch = 1'b0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (latch) seen_latch = 1'b1; end
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (latch || busy) seen_latch = 1'b1; end
    n_tests++;
    if (seen_latch !== 1'b0) begin n_fail++; $display("FAIL no_partial_latch got %b exp 0", seen_latch); end
    run_frame(1'b1, -1, 8'h00, -1, -1, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (s !== 16'h00FF) begin n_fail++; $display("FAIL bright_after_reset got %h exp 00ff", s); end
  endtask

`ifdef PWM_TEST_PANEL_REMAP_EN
  task automatic test_remap();
    logic [15:0] s; int lc, dc, nl; logic b1, ba;
    set_ramp();
    pwm_time = 8'h50;
    test_panel_select = 1'b1;
    run_frame(1'b0, -1, 8'h00, -1, -1, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (s !== 16'h03FF) begin n_fail++; $display("FAIL remap_data got %h exp 03ff", s); end
    run_frame(1'b1, -1, 8'h00, -1, -1, s, lc, dc, nl, b1, ba);
    n_tests++;
    if (s !== 16'h00FF) begin n_fail++; $display("FAIL remap_bright got %h exp 00ff", s); end
    test_panel_select = 1'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    pwm_time = '0;
    component_values = '0;
    brightness_in = '0;
    brightness_we = 1'b0;
    start = 1'b0;
    frame_sel = 1'b0;
`ifdef PWM_TEST_PANEL_REMAP_EN
    test_panel_select = 1'b0;
`endif
    test_reset();
    test_data_frame();
    test_boundary();
    test_bright_write();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef PWM_TEST_PANEL_REMAP_EN
    test_remap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
